// File: rtl/sa_fp32_mul.sv
// sa_fp32_mul: pipelined binary32 multiplier (FTZ, RNE); result valid after edge N+2 for operands sampled at edge N
module sa_fp32_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow
);
  logic               v0, v1;
  logic        [31:0] a0, b0;
  logic               sign1, zero1, inf1;
  logic        [47:0] prod1;
  logic signed [9:0]  exp1, expf;
  logic        [7:0]  ea, eb;
  logic        [23:0] ma, mb, rnd;
  logic        [22:0] mant;
  logic               za, zb, hi, g, st, ov_n, un_n;
  logic        [31:0] res_n;
  always_ff @(posedge clk) begin
    v0 <= rst ? 1'b0 : in_valid;
    if (in_valid) begin
      a0 <= a_operand;
      b0 <= b_operand;
    end
  end
  always_comb begin
    ea = a0[30:23];
    eb = b0[30:23];
    za = ea == 8'h00;
    zb = eb == 8'h00;
    ma = za ? 24'h0 : {1'b1, a0[22:0]};
    mb = zb ? 24'h0 : {1'b1, b0[22:0]};
  end
  always_ff @(posedge clk) begin
    v1 <= rst ? 1'b0 : v0;
    if (v0) begin
      sign1 <= a0[31] ^ b0[31];
      prod1 <= 48'(ma) * 48'(mb);
      exp1  <= {2'b00, ea} + {2'b00, eb} - 10'd127;
      zero1 <= za | zb;
      inf1  <= (&ea) | (&eb);
    end
  end
  // guard is the first dropped bit, sticky the OR of everything below it
  always_comb begin
    hi    = prod1[47];
    mant  = hi ? prod1[46:24] : prod1[45:23];
    g     = hi ? prod1[23] : prod1[22];
    st    = hi ? |prod1[22:0] : |prod1[21:0];
    rnd   = {1'b0, mant} + 24'(g & (st | mant[0]));
    expf  = exp1 + 10'(hi) + 10'(rnd[23]);
    ov_n  = !inf1 && !zero1 && expf >= 10'sd255;
    un_n  = !inf1 && !zero1 && !ov_n && expf <= 10'sd0;
    res_n = inf1 ? 32'h7FC00000 :
            zero1 ? {sign1, 31'b0} :
            ov_n ? {sign1, 8'hFF, 23'b0} :
            un_n ? {sign1, 31'b0} :
            {sign1, expf[7:0], rnd[22:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= 32'h0;
      Exception <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        result    <= res_n;
        Exception <= inf1;
        Overflow  <= ov_n;
        Underflow <= un_n;
      end
    end
  end
endmodule

// File: tb/tb_sa_fp32_mul.sv
// tb_sa_fp32_mul: directed vectors, random stream against a softfloat model, and reset flush
module tb_sa_fp32_mul;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] a_operand = 32'h0;
  logic [31:0] b_operand = 32'h0;
  logic        out_valid, Exception, Overflow, Underflow;
  logic [31:0] result;
  int          checks = 0;
  int          failures = 0;
  logic [34:0] q[$];
  logic [34:0] e;

  sa_fp32_mul dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a_operand(a_operand), .b_operand(b_operand),
    .out_valid(out_valid), .result(result), .Exception(Exception), .Overflow(Overflow),
    .Underflow(Underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // returns {Exception, Overflow, Underflow, result}
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, ex, sh;
    logic [47:0] p, m, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {3'b100, 32'h7FC00000};
    if (ea == 0 || eb == 0) return {3'b000, s, 31'b0};
    p    = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    ex   = ea + eb - 127 + int'(p[47]);
    sh   = p[47] ? 24 : 23;
    m    = p >> sh;
    rem  = p - (m << sh);
    half = 48'd1 << (sh - 1);
    if (rem > half || (rem == half && m[0])) m = m + 48'd1;
    if (m == 48'h1000000) begin
      m = m >> 1;
      ex++;
    end
    if (ex >= 255) return {3'b010, s, 8'hFF, 23'b0};
    if (ex <= 0) return {3'b001, s, 31'b0};
    return {3'b000, s, 8'(ex), m[22:0]};
  endfunction

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic [2:0] fl);
    @(negedge clk);
    in_valid  = 1'b1;
    a_operand = a;
    b_operand = b;
    @(negedge clk);
    in_valid  = 1'b0;
    a_operand = 'x;
    b_operand = 'x;
    chk({tag, "_v_n"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_v_n1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_v_n2"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, result, res);
    chk({tag, "_flags"}, 32'({Exception, Overflow, Underflow}), 32'(fl));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_v"}, 32'(out_valid), 32'd0);
    chk({tag, "_res"}, result, 32'h0);
    chk({tag, "_flags"}, 32'({Exception, Overflow, Underflow}), 32'd0);
  endtask

  task automatic pop_check(input int i);
    if (out_valid) begin
      if (q.size() == 0) chk($sformatf("extra_out%0d", i), 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk($sformatf("rnd%0d_res", i), result, e[31:0]);
        chk($sformatf("rnd%0d_flags", i), 32'({Exception, Overflow, Underflow}), 32'(e[34:32]));
      end
    end
  endtask

  initial begin
    logic [31:0] a, b;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    run("one_x_two", 32'h3F800000, 32'h40000000, 32'h40000000, 3'b000);
    run("sign", 32'h3FC00000, 32'hBFC00000, 32'hC0100000, 3'b000);
    run("round", 32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000);
    run("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010);
    run("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 3'b001);
    run("inf", 32'h7F800000, 32'h3F800000, 32'h7FC00000, 3'b100);
    run("negzero", 32'h80000000, 32'h3F800000, 32'h80000000, 3'b000);
    run("inf_x_zero", 32'h00000000, 32'hFF800000, 32'h7FC00000, 3'b100);
    for (int i = 0; i < 100; i++) begin
      a = {1'($urandom), 8'($urandom_range(60, 195)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(60, 195)), 23'($urandom)};
      if (i % 13 == 0) a[30:23] = 8'h00;
      if (i % 13 == 7) b[30:23] = 8'hFF;
      if (i % 11 == 5) begin
        a[22:0] = 23'h000001;
        b[22:0] = 23'h7FFFFF;
      end
      @(negedge clk);
      pop_check(i);
      in_valid  = 1'b1;
      a_operand = a;
      b_operand = b;
      q.push_back(model(a, b));
    end
    @(negedge clk);
    pop_check(100);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pop_check(101 + i);
    end
    chk("drain", 32'(q.size()), 32'd0);
    q.delete();
    @(negedge clk);
    in_valid  = 1'b1;
    a_operand = 32'h3F800000;
    b_operand = 32'h40000000;
    @(negedge clk);
    a_operand = 32'h40400000;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_idle("rst_hold0");
    @(negedge clk);
    chk_idle("rst_hold1");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle($sformatf("rst_after%0d", i));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
